// File: rtl/breath_level_gen.sv
// Triangular "breathing" intensity generator for the PWM LED stage.
// The level ramps 0->15, dwells at 15, ramps 15->0 and dwells at 0, then repeats. The step period is programmable.
module breath_level_gen #(
  parameter int STEP_TICKS = 1000000,
  parameter int HOLD_STEPS = 4,
  parameter int CNT_W      = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] speed,
  output logic [3:0] level,
  output logic       peak,
  output logic       cycle_done,
  output logic       rising,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    HOLD_LO = 2'd0,
    RISE    = 2'd1,
    HOLD_HI = 2'd2,
    FALL    = 2'd3
  } state_t;

  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
  localparam logic [CNT_W:0] ST_FULL   = (CNT_W+1)'(STEP_TICKS);

  state_t           r_state, w_state_nx;
  logic [3:0]       r_level, w_level_nx;
  logic [HW-1:0]    r_hold,  w_hold_nx;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nx;
  logic             r_peak,  w_peak_nx;
  logic             r_cd,    w_cd_nx;

  logic [CNT_W:0]   w_period;
  logic [CNT_W:0]   w_last;
  logic             w_tick;

  // ">=" rather than "==" so a speed-up mid-count ticks at once instead of wrapping.
  assign w_period = ST_FULL >> speed;
  assign w_last   = (w_period == '0) ? '0 : w_period - 1'b1;
  assign w_tick   = en && ({1'b0, r_cnt} >= w_last);

  always_comb begin
    w_cnt_nx = r_cnt;
    if (en) begin
      w_cnt_nx = w_tick ? '0 : r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_level_nx = r_level;
    w_hold_nx  = r_hold;
    w_peak_nx  = 1'b0;
    w_cd_nx    = 1'b0;
    if (w_tick) begin
      case (r_state)
        RISE: begin
          w_level_nx = r_level + 4'd1;
          if (r_level == 4'd14) begin
            w_peak_nx  = 1'b1;
            w_hold_nx  = '0;
            w_state_nx = (HOLD_STEPS == 0) ? FALL : HOLD_HI;
          end
        end
        HOLD_HI: begin
          if (r_hold == HOLD_LAST) begin
            w_hold_nx  = '0;
            w_state_nx = FALL;
          end else begin
            w_hold_nx = r_hold + 1'b1;
          end
        end
        FALL: begin
          w_level_nx = r_level - 4'd1;
          if (r_level == 4'd1) begin
            w_hold_nx = '0;
            if (HOLD_STEPS == 0) begin
              w_state_nx = RISE;
              w_cd_nx    = 1'b1;
            end else begin
              w_state_nx = HOLD_LO;
            end
          end
        end
        default: begin
          if (r_hold == HOLD_LAST) begin
            w_hold_nx  = '0;
            w_state_nx = RISE;
            w_cd_nx    = 1'b1;
          end else begin
            w_hold_nx = r_hold + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= HOLD_LO;
      r_level <= 4'd0;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_peak  <= 1'b0;
      r_cd    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_level <= w_level_nx;
      r_hold  <= w_hold_nx;
      r_cnt   <= w_cnt_nx;
      r_peak  <= w_peak_nx;
      r_cd    <= w_cd_nx;
    end
  end

  assign level       = r_level;
  assign peak        = r_peak;
  assign cycle_done  = r_cd;
  assign rising      = (r_state == RISE) || (r_state == HOLD_HI);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_breath_level_gen.sv
// Bench for breath_level_gen: two instances (4-cycle steps with a 2-step dwell, 8-cycle steps with no dwell)
// are checked every cycle against a position-in-cycle model, plus targeted scenario checks.
module tb_breath_level_gen;

  localparam int ST0 = 4;
  localparam int H0  = 2;
  localparam int ST1 = 8;
  localparam int H1  = 0;

  // Clock / reset
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] speed = 2'd0;

  logic [3:0] level0, level1;
  logic       peak0, peak1, cd0, cd1, rising0, rising1;
  logic [1:0] dbg0, dbg1;

  always #5 clk = ~clk;

  breath_level_gen #(.STEP_TICKS(ST0), .HOLD_STEPS(H0), .CNT_W(4)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .en(en), .speed(speed),
    .level(level0), .peak(peak0), .cycle_done(cd0), .rising(rising0), .o_dbg_state(dbg0)
  );

  breath_level_gen #(.STEP_TICKS(ST1), .HOLD_STEPS(H1), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .speed(speed),
    .level(level1), .peak(peak1), .cycle_done(cd1), .rising(rising1), .o_dbg_state(dbg1)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Scoreboard: {level, peak, cycle_done, rising}
  logic [6:0] exp_q0[$];
  logic [6:0] exp_q1[$];

  // Reference model: tick counter plus position of the current tick within one full cycle.
  int m_cnt[2];
  int m_pos[2];
  bit m_init[2];
  bit m_pk[2];
  bit m_cd[2];

  function automatic int lvl_of(input int pos, input int h);
    if (pos < h)               return 0;
    else if (pos < h + 15)     return pos - h;
    else if (pos < 2 * h + 15) return 15;
    else                       return 15 - (pos - (2 * h + 15));
  endfunction

  function automatic int model_level(input int k, input int h);
    return m_init[k] ? 0 : lvl_of(m_pos[k], h);
  endfunction

  function automatic logic [6:0] model_word(input int k, input int h);
    logic r;
    int   l;
    r = !m_init[k] && (m_pos[k] >= h) && (m_pos[k] < 2 * h + 15);
    l = model_level(k, h);
    return {4'(l), m_pk[k], m_cd[k], r};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_pos[k] = 0;
      m_pk[k]  = 1'b0;
      m_cd[k]  = 1'b0;
    end
    m_init[0] = (H0 == 0);
    m_init[1] = (H1 == 0);
  endtask

  task automatic model_step(input int k, input int st, input int h, input bit e, input logic [1:0] spd);
    int p;
    int np;
    p = st >> spd;
    if (p < 1) p = 1;
    m_pk[k] = 1'b0;
    m_cd[k] = 1'b0;
    if (e) begin
      if (m_cnt[k] >= p - 1) begin
        m_cnt[k] = 0;
        if (m_init[k]) begin
          m_init[k] = 1'b0;
          m_pos[k]  = 0;
          m_cd[k]   = 1'b1;
        end else begin
          np = (m_pos[k] + 1) % (30 + 2 * h);
          if (np == h)      m_cd[k] = 1'b1;
          if (np == h + 15) m_pk[k] = 1'b1;
          m_pos[k] = np;
        end
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endtask

  // Scenario tracking for the steady-run periodicity checks on instance 0.
  int cyc = 0;
  bit track = 1'b0;
  int cd0_last = -1;
  int peaks0 = 0;

  // Driver: one clock cycle with the given inputs; expectations pushed, then popped after the edge.
  task automatic step(input bit e, input logic [1:0] spd);
    @(negedge clk);
    en = e;
    speed = spd;
    model_step(0, ST0, H0, e, spd);
    model_step(1, ST1, H1, e, spd);
    exp_q0.push_back(model_word(0, H0));
    exp_q1.push_back(model_word(1, H1));
    @(posedge clk);
    #1;
    cyc++;
    check_eq("dut0_word", {level0, peak0, cd0, rising0}, exp_q0.pop_front());
    check_eq("dut1_word", {level1, peak1, cd1, rising1}, exp_q1.pop_front());
    if (peak0) check_eq("dut0_peak_at_15", level0, 15);
    if (cd0)   check_eq("dut0_cd_at_0", level0, 0);
    if (peak1) check_eq("dut1_peak_at_15", level1, 15);
    if (cd1)   check_eq("dut1_cd_at_0", level1, 0);
    if (track) begin
      if (peak0) peaks0++;
      if (cd0) begin
        if (cd0_last < 0) begin
          check_eq("first_cycle_done", cyc, 8);
        end else begin
          check_eq("cycle_done_period", cyc - cd0_last, 136);
          check_eq("peaks_per_period", peaks0, 1);
        end
        cd0_last = cyc;
        peaks0 = 0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_level0"}, level0, 0);
    check_eq({tag, "_flags0"}, {peak0, cd0, rising0}, 0);
    check_eq({tag, "_state0"}, dbg0, 0);
    check_eq({tag, "_level1"}, level1, 0);
    check_eq({tag, "_flags1"}, {peak1, cd1, rising1}, 0);
  endtask

  task automatic release_reset();
    en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    cd0_last = -1;
    peaks0 = 0;
  endtask

  initial begin
    bit         found;
    int         n;
    logic [3:0] prev;

    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_reset();

    // Scenarios 1 and 2: steady run, first cycle_done, 136-cycle period, one peak per period
    track = 1'b1;
    repeat (300) step(1'b1, 2'd0);
    track = 1'b0;
    check_eq("periods_seen", (cd0_last >= 8 + 136), 1);

    // Scenario 3: pause at level 7 mid-rise, one cycle into the step period
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1'b1, 2'd0);
      if (model_level(0, H0) == 7 && m_pos[0] < H0 + 15 && m_cnt[0] == 1) found = 1'b1;
    end
    check_eq("reach_level7", found, 1);
    repeat (50) step(1'b0, 2'd0);
    check_eq("pause_level", level0, 7);
    prev = level0;
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b1, 2'd0);
      n++;
      if (level0 != prev) found = 1'b1;
    end
    check_eq("resume_remaining_cycles", n, 3);

    // Scenario 4: speed change mid-count on instance 1 (8-cycle steps)
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 2'd0);
      if (m_cnt[1] == 5) found = 1'b1;
    end
    check_eq("reach_cnt5", found, 1);
    prev = level1;
    step(1'b1, 2'd2);
    check_eq("speed_immediate_tick", (level1 != prev), 1);
    repeat (8) step(1'b1, 2'd2);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      prev = level1;
      step(1'b1, 2'd3);
      if (level1 != prev) n++;
    end
    check_eq("speed3_every_cycle", n, 6);
    repeat (60) step(1'b1, 2'd3);

    // Randomised enable/speed mix
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
    end

    // Scenario 6: async reset mid-fall at level 12, between clock edges
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(1'b1, 2'd0);
      if (model_level(0, H0) == 12 && m_pos[0] >= 2 * H0 + 15) found = 1'b1;
    end
    check_eq("reach_fall12", found, 1);
    check_eq("fall12_level", level0, 12);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    release_reset();
    track = 1'b1;
    repeat (300) step(1'b1, 2'd0);
    track = 1'b0;
    check_eq("periods_after_reset", (cd0_last >= 8 + 136), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
